pipeline_hazard_controller: RTL and testbench

//   Sequences stall/flush control for the 5-stage pipeline around the forwarding datapath.

---
 rtl/pipeline_hazard_controller.sv | 90 +++++++++
 tb/tb_pipeline_hazard_controller.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_controller.sv
// pipeline_hazard_controller: stall/flush sequencing for load-use, taken branches and MDU waits.
// Define HAZARD_PERF_CNT_EN to enable the saturating StallCount performance counter.
module pipeline_hazard_controller #(
    parameter int MDU_TIMEOUT = 32,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       IF_ID_RsAddr,
    input  logic [4:0]       IF_ID_RtAddr,
    input  logic [4:0]       ID_EX_RtAddr,
    input  logic             ID_EX_MemRead,
    input  logic             EX_BranchTaken,
    input  logic             EX_MduStart,
    input  logic             MduDone,
    output logic             PCWrite,
    output logic             IF_ID_Write,
    output logic             IF_ID_Flush,
    output logic             ID_EX_Bubble,
    output logic             MduTimeout,
    output logic [CNT_W-1:0] StallCount
);
    localparam int TW = $clog2(MDU_TIMEOUT + 1);
    typedef enum logic {RUN, MDU_WAIT} state_t;
    state_t state_q, state_d;
    logic [TW-1:0] cnt_q, cnt_d;
    logic timeout_q, timeout_d;
    logic load_use, last;
    assign load_use = ID_EX_MemRead && (ID_EX_RtAddr != 5'd0) &&
                      ((ID_EX_RtAddr == IF_ID_RsAddr) || (ID_EX_RtAddr == IF_ID_RtAddr));
    assign last = cnt_q == TW'(MDU_TIMEOUT - 1);
    assign MduTimeout = timeout_q;
    always_comb begin
        PCWrite      = 1'b1;
        IF_ID_Write  = 1'b1;
        IF_ID_Flush  = 1'b0;
        ID_EX_Bubble = 1'b0;
        state_d      = state_q;
        cnt_d        = cnt_q;
        timeout_d    = timeout_q;
        if (state_q == RUN) begin
            if (EX_BranchTaken) begin
                IF_ID_Flush  = 1'b1;
                ID_EX_Bubble = 1'b1;
            end else if (EX_MduStart && !MduDone) begin
                PCWrite      = 1'b0;
                IF_ID_Write  = 1'b0;
                ID_EX_Bubble = 1'b1;
                state_d      = MDU_WAIT;
                cnt_d        = '0;
            end else if (load_use) begin
                PCWrite      = 1'b0;
                IF_ID_Write  = 1'b0;
                ID_EX_Bubble = 1'b1;
            end
        end else if (MduDone) begin
            state_d = RUN;
        end else begin
            PCWrite      = 1'b0;
            IF_ID_Write  = 1'b0;
            ID_EX_Bubble = 1'b1;
            cnt_d        = (&cnt_q) ? cnt_q : cnt_q + TW'(1);
            if (last) begin
                timeout_d = 1'b1;
                state_d   = RUN;
            end
        end
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= RUN;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end
`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] stall_q;
    always_ff @(posedge clk) begin
        if (!rst_n) stall_q <= '0;
        else if (!PCWrite && !(&stall_q)) stall_q <= stall_q + CNT_W'(1);
    end
    assign StallCount = stall_q;
`else
    assign StallCount = '0;
`endif
endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// tb_pipeline_hazard_controller: vector table plus MDU wait, timeout and reset sequences.
module tb_pipeline_hazard_controller;
    logic clk = 1'b0;
    logic rst_n;
    logic [4:0] rs, rt, exrt;
    logic memread, br, start, done;
    logic pcw, ifw, flush, bub, tmo;
    logic pcw4, ifw4, flush4, bub4, tmo4;
    logic [15:0] sc, sc4;
    int checks = 0;
    int errors = 0;
`ifdef HAZARD_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif
    localparam logic [3:0] IDLE = 4'b1100, STALL = 4'b0001, FLUSH = 4'b1111;

    always #5 clk = ~clk;

    pipeline_hazard_controller dut (
        .clk(clk), .rst_n(rst_n), .IF_ID_RsAddr(rs), .IF_ID_RtAddr(rt), .ID_EX_RtAddr(exrt),
        .ID_EX_MemRead(memread), .EX_BranchTaken(br), .EX_MduStart(start), .MduDone(done),
        .PCWrite(pcw), .IF_ID_Write(ifw), .IF_ID_Flush(flush), .ID_EX_Bubble(bub),
        .MduTimeout(tmo), .StallCount(sc)
    );
    pipeline_hazard_controller #(.MDU_TIMEOUT(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .IF_ID_RsAddr(rs), .IF_ID_RtAddr(rt), .ID_EX_RtAddr(exrt),
        .ID_EX_MemRead(memread), .EX_BranchTaken(br), .EX_MduStart(start), .MduDone(done),
        .PCWrite(pcw4), .IF_ID_Write(ifw4), .IF_ID_Flush(flush4), .ID_EX_Bubble(bub4),
        .MduTimeout(tmo4), .StallCount(sc4)
    );

    wire [3:0] outs  = {pcw, ifw, flush, bub};
    wire [3:0] outs4 = {pcw4, ifw4, flush4, bub4};

    typedef struct {
        logic [4:0] rs, rt, exrt;
        logic memread, br, start, done;
        logic [3:0] exp;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        rs = 0; rt = 0; exrt = 0; memread = 0; br = 0; start = 0; done = 0;
    endtask

    task automatic do_reset();
        clr();
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        #1;
    endtask

    vec_t vecs[12];

    initial begin
        vecs[0]  = '{5'd0,  5'd0, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0, IDLE};
        vecs[1]  = '{5'd8,  5'd0, 5'd8,  1'b1, 1'b0, 1'b0, 1'b0, STALL};
        vecs[2]  = '{5'd3,  5'd8, 5'd8,  1'b1, 1'b0, 1'b0, 1'b0, STALL};
        vecs[3]  = '{5'd0,  5'd0, 5'd0,  1'b1, 1'b0, 1'b0, 1'b0, IDLE};
        vecs[4]  = '{5'd8,  5'd8, 5'd8,  1'b0, 1'b0, 1'b0, 1'b0, IDLE};
        vecs[5]  = '{5'd8,  5'd7, 5'd9,  1'b1, 1'b0, 1'b0, 1'b0, IDLE};
        vecs[6]  = '{5'd0,  5'd0, 5'd0,  1'b0, 1'b1, 1'b0, 1'b0, FLUSH};
        vecs[7]  = '{5'd0,  5'd0, 5'd0,  1'b0, 1'b1, 1'b1, 1'b0, FLUSH};
        vecs[8]  = '{5'd8,  5'd0, 5'd8,  1'b1, 1'b1, 1'b0, 1'b0, FLUSH};
        vecs[9]  = '{5'd0,  5'd0, 5'd0,  1'b0, 1'b0, 1'b1, 1'b1, IDLE};
        vecs[10] = '{5'd5,  5'd0, 5'd5,  1'b1, 1'b0, 1'b1, 1'b1, STALL};
        vecs[11] = '{5'd1,  5'd31, 5'd31, 1'b1, 1'b0, 1'b0, 1'b0, STALL};

        do_reset();
        chk("reset_outs", outs, IDLE);
        chk("reset_tmo", tmo, 0);
        chk("reset_sc", sc, 0);

        foreach (vecs[i]) begin
            rs = vecs[i].rs; rt = vecs[i].rt; exrt = vecs[i].exrt;
            memread = vecs[i].memread; br = vecs[i].br; start = vecs[i].start; done = vecs[i].done;
            #1;
            chk($sformatf("vec%0d", i), outs, vecs[i].exp);
            chk($sformatf("vec%0d_t4", i), outs4, vecs[i].exp);
            cyc();
        end
        clr();
        #1;
        chk("after_table_run", outs, IDLE);
        chk("table_stallcount", sc, PERF ? 4 : 0);

        // MDU op finishing on the sixth cycle
        do_reset();
        start = 1;
        #1;
        chk("mdu_c0", outs, STALL);
        cyc();
        start = 0;
        for (int c = 1; c <= 5; c++) begin
            #1;
            chk($sformatf("mdu_c%0d", c), outs, STALL);
            cyc();
        end
        done = 1;
        #1;
        chk("mdu_done", outs, IDLE);
        cyc();
        done = 0;
        #1;
        chk("mdu_run", outs, IDLE);
        chk("mdu_sc", sc, PERF ? 6 : 0);
        chk("mdu_tmo", tmo, 0);

        // branch is ignored while waiting on the MDU
        do_reset();
        start = 1;
        cyc();
        start = 0;
        br = 1;
        #1;
        chk("wait_branch", outs, STALL);
        br = 0;
        done = 1;
        #1;
        chk("wait_branch_done", outs, IDLE);
        cyc();
        done = 0;

        // timeout on the MDU_TIMEOUT=4 instance
        do_reset();
        start = 1;
        #1;
        chk("to_start", outs4, STALL);
        cyc();
        start = 0;
        for (int c = 0; c < 4; c++) begin
            #1;
            chk($sformatf("to_wait%0d", c), outs4, STALL);
            chk($sformatf("to_tmo_low%0d", c), tmo4, 0);
            cyc();
        end
        chk("to_back_run", outs4, IDLE);
        chk("to_tmo", tmo4, 1);
        chk("to_sc", sc4, PERF ? 5 : 0);
        repeat (3) cyc();
        chk("to_sticky", tmo4, 1);
        chk("to_still_run", outs4, IDLE);

        // reset during the second MDU_WAIT cycle
        do_reset();
        start = 1;
        cyc();
        start = 0;
        cyc();
        #1;
        chk("rst_pre", outs, STALL);
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        #1;
        chk("rst_outs", outs, IDLE);
        chk("rst_tmo", tmo, 0);
        chk("rst_sc", sc, 0);
        cyc();
        chk("rst_stays_run", outs, IDLE);

        // timeout flag of the short instance is cleared by reset
        do_reset();
        start = 1;
        cyc();
        start = 0;
        repeat (4) cyc();
        chk("to2_tmo", tmo4, 1);
        do_reset();
        chk("to2_rst_tmo", tmo4, 0);
        chk("to2_rst_sc", sc4, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
